lcd_nibble_receiver: RTL and testbench

- Synthesizable receiving end of the 4-bit HD44780-style LCD bus driven by the MiniAlu LCD path. Signals: 4-bit data, RegisterSelect, ReadWrite, Enable.
- Samples the bus, reassembles high/low nibble pairs into bytes tagged with RS, and emulates the controller busy time.
- Used as an on-board bus monitor and as the checker for the software LCD driver.

---
 rtl/lcd_nibble_receiver.sv | 191 +++++++++++++++++++
 tb/tb_lcd_nibble_receiver.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/lcd_nibble_receiver.sv
// Receiving end of a 4-bit HD44780-style LCD bus.
// Synchronizes the bus, qualifies E strobes by pulse width, reassembles
// high/low nibble pairs into RS-tagged bytes and emulates the busy time.
// Optional: define LCD_CLEAR_LONG_BUSY_EN so that clear/home commands
// (0x01..0x03, RS=0) load BUSY_LONG_CYCLES instead of BUSY_CYCLES.
module lcd_nibble_receiver #(
    parameter int unsigned SYNC_STAGES      = 2,
    parameter int unsigned MIN_EN_PULSE     = 12,
    parameter int unsigned BUSY_CYCLES      = 2000,
    parameter int unsigned BUSY_LONG_CYCLES = 82000
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [3:0] iLCD,
    input  logic       iRegisterSelect,
    input  logic       iReadWrite,
    input  logic       iEnable,
    output logic [7:0] oData,
    output logic       oRS,
    output logic       oValid,
    output logic       oMode4Bit,
    output logic       oBusy,
    output logic       oOverrun,
    output logic       oError
);
    localparam int unsigned EnW     = $clog2(MIN_EN_PULSE + 1);
    localparam int unsigned BusyMax = (BUSY_LONG_CYCLES > BUSY_CYCLES) ? BUSY_LONG_CYCLES
                                                                       : BUSY_CYCLES;
    localparam int unsigned BusyW   = $clog2(BusyMax + 1);
    localparam logic [EnW-1:0]   EnMin     = EnW'(MIN_EN_PULSE);
    localparam logic [BusyW-1:0] BusyShort = BusyW'(BUSY_CYCLES);
`ifdef LCD_CLEAR_LONG_BUSY_EN
    localparam logic [BusyW-1:0] BusyLong  = BusyW'(BUSY_LONG_CYCLES);
`endif

    typedef enum logic [1:0] {StBoot, StHigh, StLow} state_e;

    // Bus word layout: {nibble[3:0], rs, rw, en}
    logic [6:0]       sync_d [SYNC_STAGES];
    logic [6:0]       sync_q [SYNC_STAGES];
    logic [6:0]       prev_d, prev_q;
    logic [EnW-1:0]   en_cnt_d, en_cnt_q;
    logic [BusyW-1:0] busy_d, busy_q;
    state_e           state_d, state_q;
    logic [3:0]       hold_nib_d, hold_nib_q;
    logic             hold_rs_d, hold_rs_q;
    logic [7:0]       data_d, data_q;
    logic             rs_d, rs_q;
    logic             valid_d, valid_q;
    logic             mode4_d, mode4_q;
    logic             overrun_d, overrun_q;
    logic             error_d, error_q;

    logic       cur_en, fall;
    logic [3:0] s_nib;
    logic       s_rs, s_rw;

    // Synchronizer chain plus one delayed copy for edge detection
    always_comb begin
        sync_d[0] = {iLCD, iRegisterSelect, iReadWrite, iEnable};
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
        prev_d = sync_q[SYNC_STAGES-1];
    end

    assign cur_en = sync_q[SYNC_STAGES-1][0];
    assign fall   = prev_q[0] & ~cur_en;
    // Sample from the last Enable-high cycle
    assign s_nib  = prev_q[6:3];
    assign s_rs   = prev_q[2];
    assign s_rw   = prev_q[1];

    // Strobe qualification, nibble assembly FSM and busy emulation
    always_comb begin
        state_d    = state_q;
        hold_nib_d = hold_nib_q;
        hold_rs_d  = hold_rs_q;
        data_d     = data_q;
        rs_d       = rs_q;
        valid_d    = 1'b0;
        mode4_d    = mode4_q;
        overrun_d  = overrun_q;
        error_d    = error_q;
        busy_d     = (busy_q != '0) ? busy_q - BusyW'(1) : '0;
        if (!cur_en) begin
            en_cnt_d = '0;
        end else if (en_cnt_q == EnMin) begin
            en_cnt_d = EnMin;
        end else begin
            en_cnt_d = en_cnt_q + EnW'(1);
        end

        if (fall) begin
            if (en_cnt_q < EnMin) begin
                error_d = 1'b1;
            end else if (!s_rw) begin
                if (busy_q != '0) begin
                    overrun_d = 1'b1;
                end
                unique case (state_q)
                    StBoot: begin
                        data_d  = {s_nib, 4'h0};
                        rs_d    = s_rs;
                        valid_d = 1'b1;
                        if (s_nib == 4'h2 && !s_rs) begin
                            state_d = StHigh;
                            mode4_d = 1'b1;
                        end
                    end
                    StHigh: begin
                        hold_nib_d = s_nib;
                        hold_rs_d  = s_rs;
                        state_d    = StLow;
                    end
                    StLow: begin
                        if (s_rs == hold_rs_q) begin
                            data_d  = {hold_nib_q, s_nib};
                            rs_d    = s_rs;
                            valid_d = 1'b1;
                            state_d = StHigh;
                        end else begin
                            // Drop the stale high nibble; this one becomes the new high
                            error_d    = 1'b1;
                            hold_nib_d = s_nib;
                            hold_rs_d  = s_rs;
                        end
                    end
                    default: state_d = StBoot;
                endcase
            end
        end

        if (valid_d) begin
`ifdef LCD_CLEAR_LONG_BUSY_EN
            if (!rs_d && (data_d == 8'h01 || data_d == 8'h02 || data_d == 8'h03)) begin
                busy_d = BusyLong;
            end else begin
                busy_d = BusyShort;
            end
`else
            busy_d = BusyShort;
`endif
        end
    end

    // State registers, all cleared asynchronously
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            prev_q     <= '0;
            en_cnt_q   <= '0;
            busy_q     <= '0;
            state_q    <= StBoot;
            hold_nib_q <= '0;
            hold_rs_q  <= 1'b0;
            data_q     <= '0;
            rs_q       <= 1'b0;
            valid_q    <= 1'b0;
            mode4_q    <= 1'b0;
            overrun_q  <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_d[i];
            end
            prev_q     <= prev_d;
            en_cnt_q   <= en_cnt_d;
            busy_q     <= busy_d;
            state_q    <= state_d;
            hold_nib_q <= hold_nib_d;
            hold_rs_q  <= hold_rs_d;
            data_q     <= data_d;
            rs_q       <= rs_d;
            valid_q    <= valid_d;
            mode4_q    <= mode4_d;
            overrun_q  <= overrun_d;
            error_q    <= error_d;
        end
    end

    assign oData     = data_q;
    assign oRS       = rs_q;
    assign oValid    = valid_q;
    assign oMode4Bit = mode4_q;
    assign oBusy     = (busy_q != '0);
    assign oOverrun  = overrun_q;
    assign oError    = error_q;
endmodule

// File: tb/tb_lcd_nibble_receiver.sv
// Self-checking bench for lcd_nibble_receiver: vector table of strobes,
// scoreboard queue of expected bytes, hand-written corner sequences.
`timescale 1ns/1ps
module tb_lcd_nibble_receiver;
    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic [3:0] iLCD = 4'h0;
    logic       iRegisterSelect = 1'b0;
    logic       iReadWrite = 1'b0;
    logic       iEnable = 1'b0;
    logic [7:0] oData;
    logic       oRS, oValid, oMode4Bit, oBusy, oOverrun, oError;

    int checks = 0;
    int errors = 0;
    logic [8:0] sb[$];  // {rs, data}

    lcd_nibble_receiver #(
        .SYNC_STAGES(2), .MIN_EN_PULSE(12), .BUSY_CYCLES(2000), .BUSY_LONG_CYCLES(82000)
    ) dut (
        .Clock(Clock), .Reset(Reset), .iLCD(iLCD), .iRegisterSelect(iRegisterSelect),
        .iReadWrite(iReadWrite), .iEnable(iEnable), .oData(oData), .oRS(oRS),
        .oValid(oValid), .oMode4Bit(oMode4Bit), .oBusy(oBusy), .oOverrun(oOverrun),
        .oError(oError)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Scoreboard consumer: every oValid pulse must match the next expected byte
    initial begin
        logic [8:0] e;
        forever begin
            @(negedge Clock);
            if (oValid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid: got rs=%b data=%h expected none", oRS, oData);
                end else begin
                    e = sb.pop_front();
                    check("valid_byte", {23'd0, oRS, oData}, {23'd0, e});
                end
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    task automatic strobe(input logic [3:0] n, input logic r, input logic w, input int hi,
                          input int gap);
        @(negedge Clock);
        iLCD = n;
        iRegisterSelect = r;
        iReadWrite = w;
        iEnable = 1'b1;
        repeat (hi) @(negedge Clock);
        iEnable = 1'b0;
        repeat (gap) @(negedge Clock);
    endtask

    task automatic measure_busy(input string name, input int exp);
        int n = 0;
        int w = 0;
        while (!oBusy && w < 20) begin
            @(negedge Clock);
            w++;
        end
        while (oBusy && n < exp + 100) begin
            n++;
            @(negedge Clock);
        end
        check(name, n, exp);
    endtask

    typedef struct {
        logic [3:0] nib;
        logic       rs;
        logic       rw;
        int         hi;
        int         gap;
        logic       push;
        logic [8:0] byte_exp;
        logic       mode4;
        logic       err;
    } vec_t;

    vec_t vecs[15];

    initial begin
        vecs[0]  = '{4'h3, 1'b0, 1'b0, 20, 2100, 1'b1, 9'h030, 1'b0, 1'b0};
        vecs[1]  = '{4'h3, 1'b0, 1'b0, 20, 2100, 1'b1, 9'h030, 1'b0, 1'b0};
        vecs[2]  = '{4'h3, 1'b0, 1'b0, 20, 2100, 1'b1, 9'h030, 1'b0, 1'b0};
        vecs[3]  = '{4'h2, 1'b0, 1'b0, 20, 2100, 1'b1, 9'h020, 1'b1, 1'b0};
        vecs[4]  = '{4'h4, 1'b1, 1'b0, 20,   30, 1'b0, 9'h000, 1'b1, 1'b0};
        vecs[5]  = '{4'h1, 1'b1, 1'b0, 20, 2100, 1'b1, 9'h141, 1'b1, 1'b0};
        // RS mismatch: 0x6 becomes the new high nibble
        vecs[6]  = '{4'h5, 1'b0, 1'b0, 20,   30, 1'b0, 9'h000, 1'b1, 1'b0};
        vecs[7]  = '{4'h6, 1'b1, 1'b0, 20,   30, 1'b0, 9'h000, 1'b1, 1'b1};
        vecs[8]  = '{4'h7, 1'b1, 1'b0, 20, 2100, 1'b1, 9'h167, 1'b1, 1'b1};
        // Short strobe is discarded
        vecs[9]  = '{4'h2, 1'b0, 1'b0,  5,   30, 1'b0, 9'h000, 1'b1, 1'b1};
        vecs[10] = '{4'h2, 1'b0, 1'b0, 20,   30, 1'b0, 9'h000, 1'b1, 1'b1};
        vecs[11] = '{4'h8, 1'b0, 1'b0, 20, 2100, 1'b1, 9'h028, 1'b1, 1'b1};
        // Read strobe between nibbles is ignored
        vecs[12] = '{4'h5, 1'b0, 1'b0, 20,   30, 1'b0, 9'h000, 1'b1, 1'b1};
        vecs[13] = '{4'h3, 1'b1, 1'b1, 20,   30, 1'b0, 9'h000, 1'b1, 1'b1};
        vecs[14] = '{4'hA, 1'b0, 1'b0, 20, 2100, 1'b1, 9'h05A, 1'b1, 1'b1};

        repeat (3) @(negedge Clock);
        check("reset_outputs", {oData, oRS, oValid, oMode4Bit, oBusy, oOverrun, oError}, 0);
        Reset = 1'b0;
        repeat (2) @(negedge Clock);

        for (int i = 0; i < 15; i++) begin
            if (vecs[i].push) sb.push_back(vecs[i].byte_exp);
            strobe(vecs[i].nib, vecs[i].rs, vecs[i].rw, vecs[i].hi, vecs[i].gap);
            check($sformatf("v%0d_drained", i), sb.size(), 0);
            check($sformatf("v%0d_mode4", i), oMode4Bit, vecs[i].mode4);
            check($sformatf("v%0d_error", i), oError, vecs[i].err);
            check($sformatf("v%0d_overrun", i), oOverrun, 1'b0);
        end

        // Busy width after a completed byte (state is HIGH here)
        strobe(4'h4, 1'b1, 1'b0, 20, 30);
        sb.push_back(9'h141);
        strobe(4'h1, 1'b1, 1'b0, 20, 0);
        measure_busy("busy_width", 2000);
        check("busy_drained", sb.size(), 0);
        check("no_overrun_yet", oOverrun, 1'b0);

        // Overrun: next byte starts 100 clocks into the busy window
        strobe(4'h4, 1'b1, 1'b0, 20, 30);
        sb.push_back(9'h141);
        strobe(4'h1, 1'b1, 1'b0, 20, 100);
        check("pre_overrun", oOverrun, 1'b0);
        sb.push_back(9'h03C);
        strobe(4'h3, 1'b0, 1'b0, 20, 30);
        check("overrun_set", oOverrun, 1'b1);
        strobe(4'hC, 1'b0, 1'b0, 20, 30);
        check("overrun_drained", sb.size(), 0);
        check("overrun_sticky", oOverrun, 1'b1);

        // Reset while in LOW
        strobe(4'h3, 1'b0, 1'b0, 20, 30);
        @(negedge Clock);
        Reset = 1'b1;
        @(negedge Clock);
        check("reset_in_low", {oData, oRS, oValid, oMode4Bit, oBusy, oOverrun, oError}, 0);
        Reset = 1'b0;
        repeat (2) @(negedge Clock);
        sb.push_back(9'h020);
        strobe(4'h2, 1'b0, 1'b0, 20, 30);
        check("boot_after_reset", sb.size(), 0);
        check("mode4_after_reset", oMode4Bit, 1'b1);

`ifdef LCD_CLEAR_LONG_BUSY_EN
        strobe(4'h0, 1'b0, 1'b0, 20, 2100);
        sb.push_back(9'h001);
        strobe(4'h1, 1'b0, 1'b0, 20, 0);
        measure_busy("long_busy_width", 82000);
        check("long_drained", sb.size(), 0);
`endif

        repeat (10) @(negedge Clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
